// File: rtl/an_sec_encoder_16bits_if.sv
// Handshake bus for the AN-code encoder: input word + error request, output codeword.
interface an_sec_encoder_16bits_if #(
  parameter int unsigned N_BITS = 17,
  parameter int unsigned W_BITS = 30,
  parameter int unsigned L_BITS = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] n;
  logic              err_en;
  logic [L_BITS-1:0] err_pos;
  logic              err_sign;
  logic              out_valid;
  logic              out_ready;
  logic [W_BITS-1:0] w;

  // Producer of data words and consumer of codewords.
  modport master (
    output in_valid, n, err_en, err_pos, err_sign, out_ready,
    input  in_ready, out_valid, w
  );

  // The encoder itself.
  modport slave (
    input  in_valid, n, err_en, err_pos, err_sign, out_ready,
    output in_ready, out_valid, w
  );
endinterface

// File: rtl/an_sec_encoder_16bits.sv
// AN-code encoder: W = A*N by iterative shift-add (one bit of A per cycle), with an
// optional +/-2^k arithmetic error injected before the codeword is presented.
module an_sec_encoder_16bits #(
  parameter int unsigned A      = 4547,
  parameter int unsigned A_BITS = 13,
  parameter int unsigned N_BITS = 17,
  parameter int unsigned W_BITS = 30,
  parameter int unsigned L_BITS = 5
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  an_sec_encoder_16bits_if.slave io_bus
);

  localparam int unsigned       CntW    = $clog2(A_BITS + 1);
  localparam logic [A_BITS-1:0] ACoef   = A_BITS'(A);
  localparam logic [CntW-1:0]   CntLast = CntW'(A_BITS - 1);

  typedef enum logic [1:0] {StIdle, StMul, StInj, StHold} state_e;

  state_e            r_state,     w_state_nxt;
  logic [N_BITS-1:0] r_n,         w_n_nxt;
  logic              r_err_en,    w_err_en_nxt;
  logic [L_BITS-1:0] r_err_pos,   w_err_pos_nxt;
  logic              r_err_sign,  w_err_sign_nxt;
  logic [W_BITS-1:0] r_acc,       w_acc_nxt;
  logic [CntW-1:0]   r_cnt,       w_cnt_nxt;
  logic [W_BITS-1:0] r_w,         w_w_nxt;
  logic              r_out_valid, w_out_valid_nxt;

  logic [W_BITS-1:0] w_n_ext;
  logic [W_BITS-1:0] w_partial;
  logic [W_BITS-1:0] w_err_mag;
  logic [W_BITS-1:0] w_inj;

  // Datapath: current shift-add term and the error-injected sum (wraps mod 2^W_BITS).
  always_comb begin
    w_n_ext   = W_BITS'(r_n);
    w_partial = ACoef[r_cnt] ? (w_n_ext << r_cnt) : '0;
    // Positions at or beyond the codeword width inject nothing.
    w_err_mag = (r_err_en && (32'(r_err_pos) < W_BITS)) ? (W_BITS'(1) << r_err_pos) : '0;
    w_inj     = r_err_sign ? (r_acc - w_err_mag) : (r_acc + w_err_mag);
  end

  // Next-state logic for the accept / multiply / inject / hold sequence.
  always_comb begin
    w_state_nxt     = r_state;
    w_n_nxt         = r_n;
    w_err_en_nxt    = r_err_en;
    w_err_pos_nxt   = r_err_pos;
    w_err_sign_nxt  = r_err_sign;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_w_nxt         = r_w;
    w_out_valid_nxt = r_out_valid;
    unique case (r_state)
      StIdle: begin
        if (io_bus.in_valid) begin
          w_n_nxt        = io_bus.n;
          w_err_en_nxt   = io_bus.err_en;
          w_err_pos_nxt  = io_bus.err_pos;
          w_err_sign_nxt = io_bus.err_sign;
          w_acc_nxt      = '0;
          w_cnt_nxt      = '0;
          w_state_nxt    = StMul;
        end
      end
      StMul: begin
        w_acc_nxt = r_acc + w_partial;
        w_cnt_nxt = r_cnt + CntW'(1);
        if (r_cnt == CntLast) begin
          w_state_nxt = StInj;
        end
      end
      StInj: begin
        w_w_nxt         = w_inj;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = StHold;
      end
      StHold: begin
        if (io_bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset; reset discards any in-flight word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_n         <= '0;
      r_err_en    <= 1'b0;
      r_err_pos   <= '0;
      r_err_sign  <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_w         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_n         <= w_n_nxt;
      r_err_en    <= w_err_en_nxt;
      r_err_pos   <= w_err_pos_nxt;
      r_err_sign  <= w_err_sign_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_w         <= w_w_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign io_bus.in_ready  = (r_state == StIdle);
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.w         = r_w;

endmodule

// File: tb/tb_an_sec_encoder_16bits.sv
// Directed table-driven bench for the AN-code encoder plus hold and mid-multiply reset cases.
module tb_an_sec_encoder_16bits;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  an_sec_encoder_16bits_if bus ();

  an_sec_encoder_16bits dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  typedef struct {
    logic [16:0] n;
    logic        err_en;
    logic [4:0]  err_pos;
    logic        err_sign;
    logic [29:0] exp_w;
  } vec_t;

  localparam int NumVec = 9;
  vec_t vecs[NumVec];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Present one word and let it be accepted; afterwards scramble the inputs.
  task automatic accept(input vec_t v, input string name);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.n        = v.n;
    bus.err_en   = v.err_en;
    bus.err_pos  = v.err_pos;
    bus.err_sign = v.err_sign;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.n        = 17'h1abcd;
    bus.err_en   = 1'b1;
    bus.err_pos  = 5'd7;
    bus.err_sign = ~v.err_sign;
    check({name, " in_ready after accept"}, 32'(bus.in_ready), 32'd0);
  endtask

  // Run one word through; out_valid must rise exactly after the 14th edge past accept.
  task automatic run_vec(input vec_t v, input string name, input bit do_handshake);
    bit early = 1'b0;
    accept(v, name);
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) early = 1'b1;
    end
    check({name, " busy during multiply"}, 32'(early), 32'd0);
    @(posedge clk);
    #1;
    check({name, " out_valid latency"}, 32'(bus.out_valid), 32'd1);
    check({name, " W"}, 32'(bus.w), 32'(v.exp_w));
    if (do_handshake) handshake(v.exp_w, name);
  endtask

  task automatic handshake(input logic [29:0] exp_w, input string name);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, " out_valid after handshake"}, 32'(bus.out_valid), 32'd0);
    check({name, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
    check({name, " W kept in idle"}, 32'(bus.w), 32'(exp_w));
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vec_t hv;
    bit   bad;
    vecs[0] = '{17'd1,      1'b0, 5'd0,  1'b0, 30'd4547};
    vecs[1] = '{17'd131071, 1'b0, 5'd0,  1'b0, 30'd595979837};
    vecs[2] = '{17'd0,      1'b0, 5'd0,  1'b0, 30'd0};
    vecs[3] = '{17'd100,    1'b1, 5'd3,  1'b0, 30'd454708};
    vecs[4] = '{17'd5,      1'b1, 5'd0,  1'b1, 30'd22734};
    vecs[5] = '{17'd0,      1'b1, 5'd0,  1'b1, 30'd1073741823};
    vecs[6] = '{17'd0,      1'b1, 5'd30, 1'b0, 30'd0};
    vecs[7] = '{17'd1,      1'b1, 5'd29, 1'b0, 30'd536875459};
    vecs[8] = '{17'd1000,   1'b1, 5'd31, 1'b1, 30'd4547000};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.n         = '0;
    bus.err_en    = 1'b0;
    bus.err_pos   = '0;
    bus.err_sign  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset W", 32'(bus.w), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);
    end

    // Stall downstream for 10 cycles while upstream keeps offering words.
    hv = '{17'd10, 1'b1, 5'd4, 1'b1, 30'd45454};
    run_vec(hv, "hold", 1'b0);
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.in_valid = k[0];
      bus.n        = 17'(k + 1);
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.w !== hv.exp_w) bad = 1'b1;
    end
    check("hold stable", 32'(bad), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    handshake(hv.exp_w, "hold");
    repeat (3) @(posedge clk);
    #1;
    check("hold nothing queued", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of a multiply discards the word.
    accept('{17'd7, 1'b0, 5'd0, 1'b0, 30'd31829}, "rst");
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid-mul reset out_valid", 32'(bus.out_valid), 32'd0);
    check("mid-mul reset W", 32'(bus.w), 32'd0);
    check("mid-mul reset in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{17'd2, 1'b0, 5'd0, 1'b0, 30'd9094}, "after reset", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
